inv_player: RTL and testbench
=============================

INV_PLAYER -- requirements
Module: inv_player

Interface
REQ-001 The block SHALL have parameter NBITS, default 264: permutation state width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8: input bits processed per cycle; NBITS/CHUNK = `nSBox` (33).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to permute state_in; sampled only in IDLE.
REQ-006 The block SHALL have port state_in, input, NBITS bits: state to invert; captured on the accepted start cycle.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a permutation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking state_out valid.
REQ-009 The block SHALL have port state_out, output, NBITS bits: inverse-permuted state; holds its value until the next accepted start.

Function
REQ-010 The block SHALL implement the inverse Spongent pLayer: input bit i moves to output bit (4*i) mod (NBITS-1) for i < NBITS-1; bit NBITS-1 maps to itself.
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE; reset enters IDLE.
REQ-012 In IDLE with start=1, the block SHALL capture state_in, clear the working output register, set index=0 and enter RUN next cycle.
REQ-013 In RUN, each cycle SHALL scatter input bits [index*CHUNK +: CHUNK] to their mapped output positions and then increment index.
REQ-014 The block SHALL leave RUN for DONE after the cycle that processes index = nSBox-1; the index counter SHALL NOT wrap.
REQ-015 In DONE, the block SHALL assert done for exactly one cycle, update state_out with the full result in the same cycle, and return to IDLE.
REQ-016 The block SHALL assert busy in RUN and DONE and deassert it in IDLE.
REQ-017 Latency SHALL be 1 + nSBox + 1 = 35 cycles from the start edge to the done edge (default).
REQ-018 The block SHALL ignore start while busy=1; state_in changes during RUN SHALL have no effect.
REQ-019 start=1 in the cycle after done SHALL be accepted normally, so back-to-back operations are allowed.
REQ-020 Mapping arithmetic SHALL be constant per bit position, computed at elaboration time; no runtime multiplier is permitted.

Reset
REQ-021 With rst=0 on a clock edge, the block SHALL set the FSM to IDLE, index to 0, busy=0, done=0, state_out=0 and the working registers to 0.
REQ-022 Reset during RUN or DONE SHALL abort the operation, suppress done for it, and discard partial results.
REQ-023 rst=0 SHALL take priority over a simultaneous start.

Configuration
REQ-024 The block SHALL support macro INV_PLAYER_PARALLEL_EN; when defined, RUN is skipped and the full inverse permutation is computed in one cycle: IDLE->DONE, done one cycle after the accepted start (latency 2), with the same interface, busy and done rules.
REQ-025 When INV_PLAYER_PARALLEL_EN is undefined, the block SHALL use the iterative CHUNK-per-cycle datapath described in REQ-013..REQ-017.

Verification
REQ-026 The bench SHALL cover: state_in with only bit 1 set, start pulse -> done at cycle 35, state_out has only bit 4 set.
REQ-027 The bench SHALL cover: only bit 66 set -> only bit 1 set; only bit 263 set -> only bit 263 set; only bit 0 set -> only bit 0 set.
REQ-028 The bench SHALL cover: state_in byte i = i for i=0..32, forward pLayer output fed to inv_player -> state_out equals the original pattern.
REQ-029 The bench SHALL cover: start re-pulsed and state_in changed mid-RUN -> no restart, result matches the first captured state, a single done pulse.
REQ-030 The bench SHALL cover: rst=0 at cycle 10 of RUN -> busy=0, state_out=0, no done; a fresh start then completes correctly in 35 cycles.
REQ-031 The bench SHALL cover: with INV_PLAYER_PARALLEL_EN defined, an all-ones input -> done at cycle 2, state_out all ones.

Source files
------------

// File: rtl/inv_player.sv
// Inverse Spongent pLayer: bit i moves to (4*i) mod (NBITS-1), MSB stays put.
// Default build scatters CHUNK bits per cycle; define INV_PLAYER_PARALLEL_EN for a single-cycle permute.
module inv_player #(
    parameter int NBITS = 264,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] state_in,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] state_out
);

    localparam int NSBOX = NBITS / CHUNK;
    localparam int IDX_W = (NSBOX > 1) ? $clog2(NSBOX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSBOX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NBITS-1:0]   r_in;
    logic [NBITS-1:0]   r_work;
    logic [NBITS-1:0]   r_out;
    logic               r_done;
    logic [IDX_W-1:0]   r_index;
    logic [NBITS-1:0]   w_scatter;
    logic [NBITS-1:0]   w_result;

    // Destination of input bit i; only ever called with loop constants, so it folds away.
    function automatic int dest(input int i);
        if (i == NBITS - 1) begin
            return i;
        end
        return (4 * i) % (NBITS - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef INV_PLAYER_PARALLEL_EN
                    w_next_state = DONE;
`else
                    w_next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (r_index == LAST_IDX) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    // Only the chunk selected by r_index lands this cycle; all other bits keep their value.
    always_comb begin
        w_scatter = r_work;
        for (int i = 0; i < NBITS; i++) begin
            if (r_index == IDX_W'(i / CHUNK)) begin
                w_scatter[dest(i)] = r_in[i];
            end
        end
    end

`ifdef INV_PLAYER_PARALLEL_EN
    always_comb begin
        w_result = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_result[dest(i)] = r_in[i];
        end
    end
`else
    always_comb begin
        w_result = r_work;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in    <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_index <= '0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_in    <= state_in;
                        r_work  <= '0;
                        r_index <= '0;
                    end
                end
                RUN: begin
                    r_work <= w_scatter;
                    if (r_index != LAST_IDX) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                DONE: begin
                    r_out <= w_result;
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign state_out = r_out;

endmodule

// File: tb/tb_inv_player.sv
// Scoreboard bench for inv_player: stimulus pushes expected results, a negedge monitor pops on done.
// Build with INV_PLAYER_PARALLEL_EN to check the single-cycle variant.
module tb_inv_player;

    localparam int NBITS = 264;
    localparam int CHUNK = 8;
`ifdef INV_PLAYER_PARALLEL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1 + NBITS / CHUNK + 1;
`endif

    typedef struct {
        logic [NBITS-1:0] data;
        int               doneCycle;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [NBITS-1:0] state_in;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] state_out;

    exp_t             expQ[$];
    logic [NBITS-1:0] lastExp;
    int               cycleCount;
    int               assertCount;
    int               failCount;

    inv_player #(.NBITS(NBITS), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycleCount = 0;
    end

    always @(posedge clk) begin
        cycleCount++;
    end

    // Reference: every input bit j is sent to (4*j) mod (N-1), the top bit to itself.
    function automatic logic [NBITS-1:0] invModel(input logic [NBITS-1:0] x);
        logic [NBITS-1:0] y;
        y = '0;
        for (int j = 0; j < NBITS; j++) begin
            y[(j == NBITS - 1) ? j : (4 * j) % (NBITS - 1)] = x[j];
        end
        return y;
    endfunction

    function automatic logic [NBITS-1:0] fwdModel(input logic [NBITS-1:0] x);
        logic [NBITS-1:0] y;
        y = '0;
        for (int j = 0; j < NBITS; j++) begin
            y[(j == NBITS - 1) ? j : (j * (NBITS / 4)) % (NBITS - 1)] = x[j];
        end
        return y;
    endfunction

    function automatic logic [NBITS-1:0] oneHot(input int b);
        logic [NBITS-1:0] y;
        y    = '0;
        y[b] = 1'b1;
        return y;
    endfunction

    function automatic logic [NBITS-1:0] randState();
        logic [287:0] t;
        for (int k = 0; k < 9; k++) begin
            t[k*32 +: 32] = $urandom;
        end
        return t[NBITS-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [NBITS-1:0] actual,
                               input logic [NBITS-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Must be called on a negedge; returns on the first negedge with busy low.
    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checkOutput("idle_timeout", {{(NBITS-1){1'b0}}, busy}, '0);
        end
    endtask

    task automatic applyStimulus(input logic [NBITS-1:0] data, input logic [NBITS-1:0] expected);
        exp_t e;
        waitIdle();
        start       = 1'b1;
        state_in    = data;
        e.data      = expected;
        e.doneCycle = cycleCount + LAT;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", NBITS'(expQ.size()), '0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", {{(NBITS-1){1'b0}}, done}, '0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                lastExp = e.data;
                checkOutput("state_out", state_out, e.data);
                checkOutput("latency", NBITS'(cycleCount), NBITS'(e.doneCycle));
            end
        end
    end

    initial begin
        logic [NBITS-1:0] bytePat;
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] c;
        assertCount = 0;
        failCount   = 0;
        lastExp     = '0;
        rst         = 1'b0;
        start       = 1'b1;
        state_in    = '1;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {{(NBITS-1){1'b0}}, busy}, '0);
        checkOutput("reset_done", {{(NBITS-1){1'b0}}, done}, '0);
        checkOutput("reset_state_out", state_out, '0);
        start    = 1'b0;
        state_in = '0;
        rst      = 1'b1;
        @(negedge clk);

        applyStimulus(oneHot(1), oneHot(4));
        applyStimulus(oneHot(66), oneHot(1));
        applyStimulus(oneHot(263), oneHot(263));
        applyStimulus(oneHot(0), oneHot(0));
        applyStimulus('1, '1);
        drain();

        for (int i = 0; i < NBITS / 8; i++) begin
            bytePat[i*8 +: 8] = 8'(i);
        end
        applyStimulus(fwdModel(bytePat), bytePat);
        drain();
        repeat (3) @(negedge clk);
        checkOutput("state_out_hold", state_out, bytePat);

        // Second start and input change while busy must not disturb the captured operation.
        a = randState();
        applyStimulus(a, invModel(a));
        repeat ((LAT > 2) ? 5 : 0) @(negedge clk);
        checkOutput("busy_in_run", {{(NBITS-1){1'b0}}, busy}, {{(NBITS-1){1'b0}}, 1'b1});
        start    = 1'b1;
        state_in = randState();
        @(negedge clk);
        start    = 1'b0;
        state_in = randState();
        drain();
        repeat (LAT + 5) @(negedge clk);

        c = randState();
        applyStimulus(c, invModel(c));
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expQ.delete();
        checkOutput("abort_busy", {{(NBITS-1){1'b0}}, busy}, '0);
        checkOutput("abort_done", {{(NBITS-1){1'b0}}, done}, '0);
        checkOutput("abort_state_out", state_out, '0);
        repeat (LAT + 5) @(negedge clk);
        applyStimulus(oneHot(1), oneHot(4));
        drain();

        for (int k = 0; k < 6; k++) begin
            a = randState();
            applyStimulus(a, invModel(a));
        end
        drain();
        repeat (LAT + 5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
